// File: rtl/rot_disp_addr.sv
// Rotary-encoder front end: synchronizes A/B/center, decodes full quadrature
// detents, and steps or clears one of several display-bank address registers.
module rot_disp_addr #(
  parameter int ADDR_WIDTH = 5,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rot_a,
  input  logic                  rot_b,
  input  logic                  rot_ctr,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  step_inc,
  output logic                  step_dec,
  output logic                  seq_err
);

  localparam int NUM_BANKS = 1 << SEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_REST = 3'd0,
    S_N1   = 3'd1,
    S_N2   = 3'd2,
    S_N3   = 3'd3,
    S_P1   = 3'd4,
    S_P2   = 3'd5,
    S_P3   = 3'd6,
    S_WAIT = 3'd7
  } state_t;

  logic r_a_meta, r_a_sync;
  logic r_b_meta, r_b_sync;
  logic r_ctr_meta, r_ctr_sync, r_ctr_prev;

  state_t r_state;
  state_t w_next;
  logic   w_inc_evt, w_dec_evt, w_err_evt;
  logic   r_inc_evt, r_dec_evt, r_err_evt;

  logic [ADDR_WIDTH-1:0] r_bank [NUM_BANKS];

  logic [1:0] w_q;
  logic       w_clr;

  assign w_q   = {r_a_sync, r_b_sync};
  assign w_clr = r_ctr_sync & ~r_ctr_prev;
  assign addr  = r_bank[sel];

  // Two-flop synchronizers for the encoder pins plus the center-edge history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_meta   <= 1'b0;
      r_a_sync   <= 1'b0;
      r_b_meta   <= 1'b0;
      r_b_sync   <= 1'b0;
      r_ctr_meta <= 1'b0;
      r_ctr_sync <= 1'b0;
      r_ctr_prev <= 1'b0;
    end else begin
      r_a_meta   <= rot_a;
      r_a_sync   <= r_a_meta;
      r_b_meta   <= rot_b;
      r_b_sync   <= r_b_meta;
      r_ctr_meta <= rot_ctr;
      r_ctr_sync <= r_ctr_meta;
      r_ctr_prev <= r_ctr_sync;
    end
  end

  // Quadrature next-state decode; any unlisted double-bit jump is an error.
  always_comb begin
    w_next    = r_state;
    w_inc_evt = 1'b0;
    w_dec_evt = 1'b0;
    w_err_evt = 1'b0;
    case (r_state)
      S_REST: case (w_q)
        2'b01:   w_next = S_N1;
        2'b10:   w_next = S_P1;
        2'b11:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_REST;
      endcase
      S_N1: case (w_q)
        2'b11:   w_next = S_N2;
        2'b00:   w_next = S_REST;
        2'b10:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_N1;
      endcase
      S_N2: case (w_q)
        2'b10:   w_next = S_N3;
        2'b01:   w_next = S_N1;
        2'b00:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_N2;
      endcase
      S_N3: case (w_q)
        2'b00:   begin w_next = S_REST; w_inc_evt = 1'b1; end
        2'b11:   w_next = S_N2;
        2'b01:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_N3;
      endcase
      S_P1: case (w_q)
        2'b11:   w_next = S_P2;
        2'b00:   w_next = S_REST;
        2'b01:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_P1;
      endcase
      S_P2: case (w_q)
        2'b01:   w_next = S_P3;
        2'b10:   w_next = S_P1;
        2'b00:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_P2;
      endcase
      S_P3: case (w_q)
        2'b00:   begin w_next = S_REST; w_dec_evt = 1'b1; end
        2'b11:   w_next = S_P2;
        2'b10:   begin w_next = S_WAIT; w_err_evt = 1'b1; end
        default: w_next = S_P3;
      endcase
      S_WAIT: begin
        if (w_q == 2'b00) begin
          w_next = S_REST;
        end else begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_WAIT;
    endcase
  end

  // State register; events are staged one cycle so pulses land the cycle after REST is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT;
      r_inc_evt <= 1'b0;
      r_dec_evt <= 1'b0;
      r_err_evt <= 1'b0;
      step_inc  <= 1'b0;
      step_dec  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_inc_evt <= w_inc_evt;
      r_dec_evt <= w_dec_evt;
      r_err_evt <= w_err_evt;
      step_inc  <= r_inc_evt;
      step_dec  <= r_dec_evt;
      seq_err   <= r_err_evt;
    end
  end

  // Bank registers: clear of the selected bank takes priority over a step on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_clr) begin
      r_bank[sel] <= '0;
    end else if (r_inc_evt) begin
      r_bank[sel] <= r_bank[sel] + ADDR_ONE;
    end else if (r_dec_evt) begin
      r_bank[sel] <= r_bank[sel] - ADDR_ONE;
    end else begin
      r_bank[sel] <= r_bank[sel];
    end
  end

endmodule

// File: tb/tb_rot_disp_addr.sv
// Scoreboard bench for rot_disp_addr: expected pulses are queued as stimulus
// is driven and matched by a monitor whenever the DUT emits a pulse.
module tb_rot_disp_addr;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_a, rot_b, rot_ctr;
  logic [1:0] sel;
  logic [4:0] addr;
  logic       step_inc, step_dec, seq_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] kind;   // 1 = inc, 2 = dec, 3 = seq_err
    logic [4:0] addr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] mon_k;
  logic [4:0] bank_m [4];

  always #5 clk = ~clk;

  rot_disp_addr #(.ADDR_WIDTH(5), .SEL_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rot_a    (rot_a),
    .rot_b    (rot_b),
    .rot_ctr  (rot_ctr),
    .sel      (sel),
    .addr     (addr),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .seq_err  (seq_err)
  );

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (step_inc || step_dec || seq_err) begin
      if ((32'(step_inc) + 32'(step_dec) + 32'(seq_err)) > 32'd1) mon_k = 2'd0;
      else if (step_inc) mon_k = 2'd1;
      else if (step_dec) mon_k = 2'd2;
      else mon_k = 2'd3;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d addr %0d, expected no pulse", mon_k, addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_k !== mon_e.kind || addr !== mon_e.addr) begin
          errors++;
          $display("FAIL pulse_match: got kind %0d addr %0d, expected kind %0d addr %0d",
                   mon_k, addr, mon_e.kind, mon_e.addr);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] kind, input logic [4:0] a);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic drive_q(input logic [1:0] q, input int n);
    @(negedge clk);
    rot_a = q[1];
    rot_b = q[0];
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic next_seq();
    drive_q(2'b01, 4); drive_q(2'b11, 4); drive_q(2'b10, 4);
    bank_m[sel] = bank_m[sel] + 5'd1;
    push_exp(2'd1, bank_m[sel]);
    drive_q(2'b00, 6);
  endtask

  task automatic prev_seq();
    drive_q(2'b10, 4); drive_q(2'b11, 4); drive_q(2'b01, 4);
    bank_m[sel] = bank_m[sel] - 5'd1;
    push_exp(2'd2, bank_m[sel]);
    drive_q(2'b00, 6);
  endtask

  task automatic set_sel(input logic [1:0] s);
    @(negedge clk);
    sel = s;
    #1;
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (addr !== 5'd0 || step_inc !== 1'b0 || step_dec !== 1'b0 || seq_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: sel %0d addr %0d pulses %b%b%b, expected 0/000",
                 s, addr, step_inc, step_dec, seq_err);
      end
    end
    sel = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_q_empty("reset_quiet");
  endtask

  task automatic test_next_latency();
    set_sel(2'd0);
    drive_q(2'b01, 4); drive_q(2'b11, 4); drive_q(2'b10, 4);
    bank_m[0] = 5'd1;
    push_exp(2'd1, 5'd1);
    @(negedge clk);
    rot_a = 1'b0; rot_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (addr !== 5'd0 || step_inc !== 1'b0) begin
        errors++;
        $display("FAIL next_early: edge %0d addr %0d inc %b, expected 0/0", i, addr, step_inc);
      end
    end
    @(negedge clk);
    checks++;
    if (addr !== 5'd1 || step_inc !== 1'b1) begin
      errors++;
      $display("FAIL next_latency: addr %0d inc %b, expected 1/1", addr, step_inc);
    end
    repeat (4) @(negedge clk);
    for (int s = 1; s < 4; s++) begin
      set_sel(2'(s));
      checks++;
      if (addr !== 5'd0) begin
        errors++;
        $display("FAIL other_banks: sel %0d addr %0d, expected 0", s, addr);
      end
    end
    set_sel(2'd0);
    check_q_empty("next_pulses");
  endtask

  task automatic test_prev_wrap();
    set_sel(2'd1);
    prev_seq();
    checks++;
    if (addr !== 5'd31) begin
      errors++;
      $display("FAIL prev_wrap: addr %0d, expected 31", addr);
    end
    next_seq();
    next_seq();
    checks++;
    if (addr !== 5'd1) begin
      errors++;
      $display("FAIL next_wrap: addr %0d, expected 1", addr);
    end
    set_sel(2'd0);
    checks++;
    if (addr !== bank_m[0]) begin
      errors++;
      $display("FAIL bank0_hold: addr %0d, expected %0d", addr, bank_m[0]);
    end
    check_q_empty("prev_pulses");
  endtask

  task automatic test_reversal();
    drive_q(2'b01, 4); drive_q(2'b11, 4); drive_q(2'b01, 4); drive_q(2'b00, 6);
    checks++;
    if (addr !== bank_m[0]) begin
      errors++;
      $display("FAIL reversal_addr: addr %0d, expected %0d", addr, bank_m[0]);
    end
    check_q_empty("reversal_no_pulse");
  endtask

  task automatic test_seq_err();
    push_exp(2'd3, bank_m[0]);
    drive_q(2'b11, 6); drive_q(2'b10, 4); drive_q(2'b00, 6);
    check_q_empty("seq_err_recover");
    next_seq();
    checks++;
    if (addr !== bank_m[0]) begin
      errors++;
      $display("FAIL seq_err_resume: addr %0d, expected %0d", addr, bank_m[0]);
    end
    check_q_empty("seq_err_resume_pulse");
  endtask

  task automatic test_clear();
    set_sel(2'd2);
    repeat (5) next_seq();
    checks++;
    if (addr !== 5'd5) begin
      errors++;
      $display("FAIL clear_setup: addr %0d, expected 5", addr);
    end
    @(negedge clk);
    rot_ctr = 1'b1;
    bank_m[2] = 5'd0;
    repeat (4) @(negedge clk);
    checks++;
    if (addr !== 5'd0) begin
      errors++;
      $display("FAIL clear_hold: addr %0d, expected 0", addr);
    end
    // A step while the button is still held must survive: the clear fires only once.
    next_seq();
    repeat (28) @(negedge clk);
    checks++;
    if (addr !== 5'd1) begin
      errors++;
      $display("FAIL clear_once: addr %0d, expected 1", addr);
    end
    @(negedge clk);
    rot_ctr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (addr !== 5'd1) begin
      errors++;
      $display("FAIL clear_release: addr %0d, expected 1", addr);
    end
    drive_q(2'b01, 4); drive_q(2'b11, 4); drive_q(2'b10, 4);
    bank_m[2] = 5'd0;
    push_exp(2'd1, 5'd0);
    @(negedge clk);
    rot_a = 1'b0; rot_b = 1'b0;
    @(negedge clk);
    rot_ctr = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (addr !== 5'd0 || step_inc !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_step: addr %0d inc %b, expected 0/1", addr, step_inc);
    end
    repeat (4) @(negedge clk);
    rot_ctr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (addr !== 5'd0) begin
      errors++;
      $display("FAIL clear_vs_step_hold: addr %0d, expected 0", addr);
    end
    check_q_empty("clear_pulses");
  endtask

  task automatic test_rst_mid();
    set_sel(2'd3);
    next_seq();
    next_seq();
    drive_q(2'b01, 4); drive_q(2'b11, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (addr !== 5'd0) begin
        errors++;
        $display("FAIL rst_mid_banks: sel %0d addr %0d, expected 0", s, addr);
      end
      bank_m[s] = 5'd0;
    end
    sel = 2'd3;
    rst = 1'b0;
    // Synchronizers restart at 00, so the held 11 reaches the FSM as an illegal 00->11 jump.
    push_exp(2'd3, 5'd0);
    drive_q(2'b11, 6); drive_q(2'b10, 4); drive_q(2'b00, 6);
    check_q_empty("rst_mid_wait_rest");
    next_seq();
    checks++;
    if (addr !== 5'd1) begin
      errors++;
      $display("FAIL rst_mid_resume: addr %0d, expected 1", addr);
    end
    check_q_empty("rst_mid_pulses");
  endtask

  initial begin
    rst = 1'b1;
    rot_a = 1'b0;
    rot_b = 1'b0;
    rot_ctr = 1'b0;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) bank_m[i] = 5'd0;
    repeat (4) @(negedge clk);
    test_reset();
    test_next_latency();
    test_prev_wrap();
    test_reversal();
    test_seq_err();
    test_clear();
    test_rst_mid();
    repeat (5) @(negedge clk);
    check_q_empty("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
